// File: rtl/gpc_stream_acc.sv
// -----------------------------------------------------------------------------
// gpc_stream_acc
//   Pipelined generalised parallel counter with a valid/ready stream interface.
//   Three input columns carry weights 1, 2 and 4.  Each accepted beat's
//   weighted popcount is either emitted directly or, in accumulate mode,
//   summed across a burst with a saturating accumulator.
//
//   Pipeline:
//     S1  per-column popcounts plus acc_mode / in_last, registered on accept
//     S2  weighted sum, accumulate/saturate, output register (dst, out_sat)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready
//   src0       weight-1 bits (N0)
//   src1       weight-2 bits (N1)
//   src2       weight-4 bits (N2)
//   acc_mode   1 = beat belongs to an accumulating burst
//   in_last    final beat of a burst (ignored when acc_mode = 0)
//   out_valid  output beat valid
//   out_ready  output beat consumed when out_valid && out_ready
//   dst        result, zero-extended to ACC_W
//   out_sat    accumulated result was clipped to 2^ACC_W-1
// -----------------------------------------------------------------------------
module gpc_stream_acc #(
   parameter int N0    = 5,
   parameter int N1    = 3,
   parameter int N2    = 1,
   parameter int ACC_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N0-1:0]    src0,
   input  logic [N1-1:0]    src1,
   input  logic [N2-1:0]    src2,
   input  logic             acc_mode,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] dst,
   output logic             out_sat
);

   localparam int OUT_W = $clog2(N0 + 2*N1 + 4*N2 + 1);
   localparam int P0_W  = $clog2(N0 + 1);
   localparam int P1_W  = $clog2(N1 + 1);
   localparam int P2_W  = $clog2(N2 + 1);
   localparam int AW1   = ACC_W + 1;

   // Column widths are assumed to be at most 32 bits.
   function automatic logic [31:0] popcount(input logic [31:0] v);
      logic [31:0] c;
      c = '0;
      for (int i = 0; i < 32; i++) begin
         c = c + {31'b0, v[i]};
      end
      return c;
   endfunction

   // x is one bit wider than the accumulator; the top bit flags overflow.
   function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] x);
      return x[ACC_W] ? {ACC_W{1'b1}} : x[ACC_W-1:0];
   endfunction

   // S1 state
   logic             s1_valid_q, s1_valid_d;
   logic [P0_W-1:0]  p0_q;
   logic [P1_W-1:0]  p1_q;
   logic [P2_W-1:0]  p2_q;
   logic             s1_acc_q;
   logic             s1_last_q;

   // S2 / output state
   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] dst_q, dst_d;
   logic             out_sat_q, out_sat_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             acc_sat_q, acc_sat_d;

   logic             emitting;
   logic             s1_adv;
   logic             accept;
   logic [OUT_W-1:0] sum;
   logic [ACC_W:0]   acc_ext;
   logic             ovf;

   always_comb begin
      // An absorbing beat only touches the accumulator, so it can always
      // drain from S1 even while the output register is blocked.
      emitting = !s1_acc_q || s1_last_q;
      s1_adv   = s1_valid_q && (!emitting || !out_valid_q || out_ready);
      in_ready = !s1_valid_q || s1_adv;
      accept   = in_valid && in_ready;

      sum      = OUT_W'(p0_q) + OUT_W'({p1_q, 1'b0}) + OUT_W'({p2_q, 2'b00});
      acc_ext  = {1'b0, acc_q} + AW1'(sum);
      ovf      = acc_ext[ACC_W];

      s1_valid_d  = s1_valid_q;
      out_valid_d = out_valid_q;
      dst_d       = dst_q;
      out_sat_d   = out_sat_q;
      acc_d       = acc_q;
      acc_sat_d   = acc_sat_q;

      if (accept) begin
         s1_valid_d = 1'b1;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (s1_adv) begin
         if (!s1_acc_q) begin
            dst_d       = ACC_W'(sum);
            out_sat_d   = 1'b0;
            out_valid_d = 1'b1;
         end else if (!s1_last_q) begin
            acc_d     = sat_acc(acc_ext);
            acc_sat_d = acc_sat_q | ovf;
         end else begin
            dst_d       = sat_acc(acc_ext);
            out_sat_d   = acc_sat_q | ovf;
            out_valid_d = 1'b1;
            acc_d       = '0;
            acc_sat_d   = 1'b0;
         end
      end
   end

   // ---- S1 data: captured on accept, qualified by s1_valid_q ----
   always_ff @(posedge clk) begin
      if (accept) begin
         p0_q      <= P0_W'(popcount(32'(src0)));
         p1_q      <= P1_W'(popcount(32'(src1)));
         p2_q      <= P2_W'(popcount(32'(src2)));
         s1_acc_q  <= acc_mode;
         s1_last_q <= in_last;
      end
   end

   // ---- S1 control and S2 / output registers ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         dst_q       <= '0;
         out_sat_q   <= 1'b0;
         acc_q       <= '0;
         acc_sat_q   <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         dst_q       <= dst_d;
         out_sat_q   <= out_sat_d;
         acc_q       <= acc_d;
         acc_sat_q   <= acc_sat_d;
      end
   end

   assign out_valid = out_valid_q;
   assign dst       = dst_q;
   assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_gpc_stream_acc.sv
// -----------------------------------------------------------------------------
// tb_gpc_stream_acc
//   Table-driven vectors plus hand-written multi-cycle sequences.  Expected
//   output beats are pushed to a scoreboard queue when the input beat is
//   accepted and popped by a monitor when the DUT hands an output beat over.
// -----------------------------------------------------------------------------
module tb_gpc_stream_acc;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] src0;
   logic [2:0] src1;
   logic [0:0] src2;
   logic       acc_mode;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] dst;
   logic       out_sat;

   gpc_stream_acc #(.N0(5), .N1(3), .N2(1), .ACC_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .src0     (src0),
      .src1     (src1),
      .src2     (src2),
      .acc_mode (acc_mode),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .dst      (dst),
      .out_sat  (out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int d;
      bit s;
   } exp_t;

   typedef struct {
      logic [4:0] s0;
      logic [2:0] s1;
      logic [0:0] s2;
      bit         am;
      bit         lst;
      int         ed;
      bit         es;
   } vec_t;

   exp_t q[$];
   vec_t tbl[$];

   int  ncmp = 0;
   int  nerr = 0;
   int  m_acc = 0;
   bit  m_sat = 0;
   bit  rnd_on = 0;
   bit  bp_done = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Drive one beat and hold it until accepted.  The reference model tracks
   // the accumulator; use_tbl substitutes a hand-computed expectation.
   task automatic send(input logic [4:0] s0, input logic [2:0] s1, input logic [0:0] s2,
                       input bit am, input bit lst, input bit use_tbl,
                       input int ed, input bit es, input bit push_en);
      int   n;
      bit   taken;
      int   s;
      int   t;
      bit   ov;
      exp_t e;
      in_valid = 1'b1;
      src0 = s0; src1 = s1; src2 = s2; acc_mode = am; in_last = lst;
      n = 0;
      taken = 1'b0;
      while (!taken && n < 200) begin
         @(negedge clk);
         taken = in_ready;
         @(posedge clk);
         n++;
      end
      #1;
      in_valid = 1'b0;
      if (!taken) begin
         ncmp++;
         nerr++;
         $display("FAIL send_timeout: in_ready stayed %0d, expected 1", in_ready);
      end else begin
         s = $countones(s0) + 2*$countones(s1) + 4*$countones(s2);
         e.d = -1;
         e.s = 1'b0;
         if (!am) begin
            e.d = s;
         end else begin
            t  = m_acc + s;
            ov = (t > 255);
            if (ov) t = 255;
            if (!lst) begin
               m_acc = t;
               m_sat = m_sat | ov;
            end else begin
               e.d = t;
               e.s = m_sat | ov;
               m_acc = 0;
               m_sat = 1'b0;
            end
         end
         if (e.d >= 0 && push_en) begin
            if (use_tbl) begin
               e.d = ed;
               e.s = es;
            end
            q.push_back(e);
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      #1;
      while ((q.size() != 0 || out_valid) && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_queue_empty", q.size(), 0);
   endtask

   // Output monitor: out_ready only changes just after a rising edge, so the
   // handshake seen here is the one taken at the next rising edge.
   always @(negedge clk) begin
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (q.size() == 0) begin
            ncmp++;
            nerr++;
            $display("FAIL unexpected_beat: got dst=%0d out_sat=%0d, expected no beat", dst, out_sat);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("out_dst", dst, e.d);
            chk("out_sat", out_sat, e.s);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      src0 = '0; src1 = '0; src2 = '0;
      acc_mode = 1'b0;
      in_last = 1'b0;
      out_ready = 1'b1;

      tbl.push_back('{5'h1f, 3'h7, 1'b1, 1'b0, 1'b0, 15, 1'b0});
      tbl.push_back('{5'h00, 3'h0, 1'b0, 1'b0, 1'b0,  0, 1'b0});
      tbl.push_back('{5'h08, 3'h5, 1'b1, 1'b0, 1'b0,  9, 1'b0});
      tbl.push_back('{5'h00, 3'h7, 1'b0, 1'b0, 1'b1,  6, 1'b0});
      tbl.push_back('{5'h1f, 3'h7, 1'b1, 1'b1, 1'b0,  0, 1'b0});
      tbl.push_back('{5'h1f, 3'h7, 1'b1, 1'b1, 1'b0,  0, 1'b0});
      tbl.push_back('{5'h1f, 3'h7, 1'b1, 1'b1, 1'b0,  0, 1'b0});
      tbl.push_back('{5'h1f, 3'h7, 1'b1, 1'b1, 1'b1, 60, 1'b0});
      tbl.push_back('{5'h08, 3'h5, 1'b1, 1'b1, 1'b1,  9, 1'b0});
      tbl.push_back('{5'h1f, 3'h7, 1'b1, 1'b1, 1'b0,  0, 1'b0});
      tbl.push_back('{5'h08, 3'h5, 1'b1, 1'b0, 1'b0,  9, 1'b0});
      tbl.push_back('{5'h00, 3'h7, 1'b0, 1'b1, 1'b1, 21, 1'b0});
      tbl.push_back('{5'h03, 3'h0, 1'b0, 1'b0, 1'b0,  2, 1'b0});
      tbl.push_back('{5'h10, 3'h2, 1'b0, 1'b0, 1'b0,  3, 1'b0});

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dst", dst, 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_in_ready", in_ready, 1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Pass-through latency: beat presented now, accepted at the next edge,
      // output register loaded at the edge after that.
      q.push_back('{9, 1'b0});
      in_valid = 1'b1;
      src0 = 5'h08; src1 = 3'h5; src2 = 1'b1; acc_mode = 1'b0; in_last = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("lat_edge1_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
      chk("lat_edge2_out_valid", out_valid, 1);
      chk("lat_edge2_dst", dst, 9);
      drain();

      // Table vectors, back-to-back
      foreach (tbl[i]) begin
         send(tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].am, tbl[i].lst, 1'b1,
              tbl[i].ed, tbl[i].es, 1'b1);
      end
      drain();

      // Saturation: twenty beats of 15, then a fresh single-beat burst
      for (int i = 0; i < 19; i++) send(5'h1f, 3'h7, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
      send(5'h1f, 3'h7, 1'b1, 1'b1, 1'b1, 1'b1, 255, 1'b1, 1'b1);
      send(5'h08, 3'h5, 1'b1, 1'b1, 1'b1, 1'b1, 9, 1'b0, 1'b1);
      drain();

      // Backpressure: 9, 6, 15 offered with out_ready low
      out_ready = 1'b0;
      bp_done = 1'b0;
      fork
         begin
            send(5'h08, 3'h5, 1'b1, 1'b0, 1'b0, 1'b1,  9, 1'b0, 1'b1);
            send(5'h00, 3'h7, 1'b0, 1'b0, 1'b0, 1'b1,  6, 1'b0, 1'b1);
            send(5'h1f, 3'h7, 1'b1, 1'b0, 1'b0, 1'b1, 15, 1'b0, 1'b1);
            bp_done = 1'b1;
         end
      join_none
      repeat (4) @(posedge clk);
      #1;
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_dst_held", dst, 9);
      // Absorbing beats may not bypass a blocked emitting beat's slot here;
      // just verify the output stays frozen for a few more cycles.
      repeat (3) @(posedge clk);
      #1;
      chk("bp_dst_still_held", dst, 9);
      chk("bp_queue_depth", q.size(), 2);
      out_ready = 1'b1;
      for (int i = 0; i < 50 && !bp_done; i++) @(posedge clk);
      #1;
      chk("bp_sender_done", bp_done, 1);
      drain();

      // Absorbing beats never stall while the output is blocked
      out_ready = 1'b0;
      send(5'h08, 3'h5, 1'b1, 1'b0, 1'b0, 1'b1, 9, 1'b0, 1'b1);
      send(5'h1f, 3'h7, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
      send(5'h1f, 3'h7, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
      send(5'h1f, 3'h7, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      chk("absorb_in_ready", in_ready, 1);
      out_ready = 1'b1;
      send(5'h00, 3'h0, 1'b0, 1'b1, 1'b1, 1'b1, 45, 1'b0, 1'b1);
      drain();

      // Reset mid-burst: partial accumulation is discarded
      send(5'h1f, 3'h7, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
      send(5'h1f, 3'h7, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
      rst = 1'b1;
      #1;
      chk("rst_mid_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_acc = 0;
      m_sat = 1'b0;
      q.delete();
      send(5'h08, 3'h5, 1'b1, 1'b1, 1'b1, 1'b1, 9, 1'b0, 1'b1);
      drain();

      // Reset pulse while an output beat is pending
      out_ready = 1'b0;
      send(5'h1f, 3'h7, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 10 && !out_valid; i++) begin
         @(posedge clk);
         #1;
      end
      chk("rstpulse_pre_out_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("rstpulse_out_valid", out_valid, 0);
      chk("rstpulse_dst", dst, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("rstpulse_quiet", out_valid, 0);

      // Random beats with random backpressure against the reference model
      rnd_on = 1'b1;
      fork
         begin
            while (rnd_on) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join_none
      for (int i = 0; i < 500; i++) begin
         logic [4:0] r0;
         logic [2:0] r1;
         logic [0:0] r2;
         bit         am;
         bit         lst;
         r0  = 5'($urandom);
         r1  = 3'($urandom);
         r2  = 1'($urandom);
         am  = ($urandom_range(0, 2) == 0);
         lst = am && ($urandom_range(0, 3) == 0);
         send(r0, r1, r2, am, lst, 1'b0, 0, 1'b0, 1'b1);
      end
      send(5'h00, 3'h0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1);
      rnd_on = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      out_ready = 1'b1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
      $finish;
   end

endmodule
